// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared AXI4-Lite response codes, protection values and bridge states
package axi4lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_INSTR = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WADDR_DATA = 3'd1,
    S_WRESP      = 3'd2,
    S_RADDR      = 3'd3,
    S_RDATA      = 3'd4,
    S_DONE       = 3'd5
  } state_e;

endpackage

// File: rtl/axi4lite_master_bridge.sv
// rtl/axi4lite_master_bridge.sv - PicoRV32 native bus to single-outstanding AXI4-Lite master
module axi4lite_master_bridge
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  output logic              bus_err,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [2:0]        prot_q, prot_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic              bready_q, bready_d, rready_q, rready_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              bus_err_q, bus_err_d, timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic busy, wd_hit, aw_fire, w_fire;

  assign busy    = (state_q == S_WADDR_DATA) || (state_q == S_WRESP) ||
                   (state_q == S_RADDR) || (state_q == S_RDATA);
  assign wd_hit  = (TIMEOUT_CYCLES != 0) && busy && (32'(wd_cnt_q) == TIMEOUT_CYCLES - 1);
  assign aw_fire = awvalid_q && awready;
  assign w_fire  = wvalid_q && wready;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    prot_d        = prot_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    mem_rdata_d   = mem_rdata_q;
    bus_err_d     = bus_err_q;
    timeout_err_d = timeout_err_q;
    wd_cnt_d      = busy ? wd_cnt_q + CNT_W'(1) : '0;

    unique case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          prot_d    = mem_instr ? PROT_INSTR : PROT_DATA;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (|mem_wstrb) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WADDR_DATA: begin
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bvalid && bready_q) begin
          bready_d = 1'b0;
          state_d  = S_DONE;
          if (bresp != OKAY) bus_err_d = 1'b1;
        end
      end
      S_RADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rvalid && rready_q) begin
          rready_d = 1'b0;
          state_d  = S_DONE;
          if (rresp == OKAY) begin
            mem_rdata_d = rdata;
          end else begin
            mem_rdata_d = ERR_RDATA;
            bus_err_d   = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort path drops valids mid-handshake; only meant to unwedge a dead environment.
    if (wd_hit) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      mem_rdata_d   = ERR_RDATA;
      bus_err_d     = 1'b1;
      timeout_err_d = 1'b1;
      state_d       = S_DONE;
    end

    mem_ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      prot_q        <= PROT_DATA;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      mem_ready_q   <= 1'b0;
      mem_rdata_q   <= '0;
      bus_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      prot_q        <= prot_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      mem_ready_q   <= mem_ready_d;
      mem_rdata_q   <= mem_rdata_d;
      bus_err_q     <= bus_err_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign mem_ready   = mem_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign awvalid     = awvalid_q;
  assign awaddr      = addr_q;
  assign awprot      = PROT_DATA;
  assign wvalid      = wvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign bready      = bready_q;
  assign arvalid     = arvalid_q;
  assign araddr      = addr_q;
  assign arprot      = prot_q;
  assign rready      = rready_q;
  assign bus_err     = bus_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// tb/tb_axi4lite_master_bridge.sv - directed self-checking bench with a behavioural AXI4-Lite slave
module tb_axi4lite_master_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0, mem_ready;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;
  logic        bus_err, timeout_err;

  axi4lite_master_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .bus_err(bus_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // slave configuration
  int   aw_lat = 0, w_lat = 0;
  logic ar_never = 1'b0, b_never = 1'b0, r_err = 1'b0;

  // slave state and monitors
  logic [31:0] smem [0:63];
  int   aw_cnt = 0, w_cnt = 0;
  logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic [31:0] aw_a, w_d, r_d;
  logic [3:0]  w_s;
  logic [1:0]  r_rsp;
  logic        aw_prev_v = 1'b0;
  logic [31:0] aw_prev_a;
  int   aw_hs, w_hs, ar_hs, aw_hi, w_hi, ar_hi, rdy_cnt, aw_unstable, overlap;
  logic [31:0] last_araddr;
  logic [2:0]  last_arprot;

  // Slave runs on the falling edge: readies/valids settle well before the DUT samples them.
  always @(negedge clk) begin
    if (reset) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
      aw_prev_v = 1'b0;
    end else begin
      bvalid = b_pend && !b_never;
      bresp  = 2'b00;
      rvalid = r_pend;
      rdata  = r_d;
      rresp  = r_rsp;
      if (awvalid) begin awready = (aw_cnt == aw_lat); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt == w_lat); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      arready = arvalid && !ar_never;

      if (awvalid && aw_prev_v && (awaddr != aw_prev_a)) aw_unstable++;
      aw_prev_v = awvalid;
      aw_prev_a = awaddr;
      if (awvalid && arvalid) overlap++;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (arvalid) ar_hi++;
      if (mem_ready) rdy_cnt++;

      if (awvalid && awready) begin aw_hs++; aw_got = 1'b1; aw_a = awaddr; end
      if (wvalid && wready) begin w_hs++; w_got = 1'b1; w_d = wdata; w_s = wstrb; end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) smem[aw_a[7:2]][8*b +: 8] = w_d[8*b +: 8];
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
      end
      if (bvalid && bready) b_pend = 1'b0;
      if (arvalid && arready) begin
        ar_hs++; last_araddr = araddr; last_arprot = arprot; r_pend = 1'b1;
        r_d   = r_err ? 32'h0000_1234 : smem[araddr[7:2]];
        r_rsp = r_err ? 2'b10 : 2'b00;
      end
      if (rvalid && rready) r_pend = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    aw_hs = 0; w_hs = 0; ar_hs = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
    rdy_cnt = 0; aw_unstable = 0;
  endtask

  // Called just after a rising edge; returns read data and cycles to mem_ready.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic instr, output logic [31:0] rd, output int lat);
    clr_stats();
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = instr;
    lat = 0; rd = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin lat = i; rd = mem_rdata; break; end
    end
    mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    chk("txn_completed", 32'(lat != 0), 32'd1);
    @(posedge clk); #1;
    chk("mem_ready_one_cycle", 32'(mem_ready), 32'd0);
    chk("mem_ready_pulse_count", 32'(rdy_cnt), 32'd1);
  endtask

  logic [31:0] rd;
  int lat;

  initial begin
    for (int i = 0; i < 64; i++) smem[i] = '0;
    overlap = 0;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_outputs", 32'({awvalid, wvalid, arvalid, bready, rready, mem_ready, bus_err, timeout_err}), 32'd0);
    chk("reset_mem_rdata", mem_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // zero-wait write
    txn(32'h10, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat);
    chk("wr_aw_handshakes", 32'(aw_hs), 32'd1);
    chk("wr_w_handshakes", 32'(w_hs), 32'd1);
    chk("wr_slave_mem", smem[4], 32'hCAFE_F00D);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_bus_err", 32'(bus_err), 32'd0);

    // instruction read-back
    txn(32'h10, 32'h0, 4'h0, 1'b1, rd, lat);
    chk("rd_rdata", rd, 32'hCAFE_F00D);
    chk("rd_araddr", last_araddr, 32'h10);
    chk("rd_arprot", 32'(last_arprot), 32'h4);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_ar_handshakes", 32'(ar_hs), 32'd1);

    // skewed write: W accepted immediately, AW three cycles later; half-word strobe
    aw_lat = 3;
    txn(32'h20, 32'h1111_2222, 4'h3, 1'b0, rd, lat);
    aw_lat = 0;
    chk("skew_wvalid_cycles", 32'(w_hi), 32'd1);
    chk("skew_awvalid_cycles", 32'(aw_hi), 32'd4);
    chk("skew_awaddr_stable", 32'(aw_unstable), 32'd0);
    chk("skew_aw_handshakes", 32'(aw_hs), 32'd1);
    chk("skew_slave_mem", smem[8], 32'h0000_2222);
    chk("skew_latency", 32'(lat), 32'd6);

    // read with SLVERR, then a clean read keeps the sticky error
    r_err = 1'b1;
    txn(32'h30, 32'h0, 4'h0, 1'b0, rd, lat);
    r_err = 1'b0;
    chk("slverr_rdata", rd, 32'hDEAD_BEEF);
    chk("slverr_bus_err", 32'(bus_err), 32'd1);
    chk("slverr_timeout_err", 32'(timeout_err), 32'd0);
    txn(32'h10, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("post_err_rdata", rd, 32'hCAFE_F00D);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);

    // dead slave: watchdog aborts after 16 cycles in RADDR
    ar_never = 1'b1;
    txn(32'h40, 32'h0, 4'h0, 1'b0, rd, lat);
    ar_never = 1'b0;
    chk("wd_arvalid_cycles", 32'(ar_hi), 32'd16);
    chk("wd_rdata", rd, 32'hDEAD_BEEF);
    chk("wd_latency", 32'(lat), 32'd17);
    chk("wd_timeout_err", 32'(timeout_err), 32'd1);
    chk("wd_arvalid_low", 32'(arvalid), 32'd0);
    txn(32'h10, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("post_wd_rdata", rd, 32'hCAFE_F00D);
    chk("post_wd_latency", 32'(lat), 32'd3);

    // reset while waiting in WRESP
    b_never = 1'b1;
    mem_valid = 1'b1; mem_addr = 32'h24; mem_wdata = 32'h5555_AAAA; mem_wstrb = 4'hF;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bready) begin lat = i; break; end
    end
    chk("reach_wresp", 32'(lat != 0), 32'd1);
    reset = 1'b1; mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;
    chk("rst_wresp_ctrl_outputs", 32'({awvalid, wvalid, arvalid, bready, rready, mem_ready}), 32'd0);
    chk("rst_wresp_errors", 32'({bus_err, timeout_err}), 32'd0);
    chk("rst_wresp_mem_rdata", mem_rdata, 32'd0);
    reset = 1'b0; b_never = 1'b0;
    @(posedge clk); #1;
    txn(32'h10, 32'h0, 4'h0, 1'b0, rd, lat);
    chk("post_rst_rdata", rd, 32'hCAFE_F00D);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("never_aw_with_ar", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
